// File: rtl/btn_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel push-button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_e;

    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debouncer channel: stability FSM, tick counter and registered level/pulse outputs.
// Define BTN_DEBOUNCE_AUTO_REPEAT_EN to add auto-repeat press pulses while held.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 8,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic TICK,
    input  logic btn_sync,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    if (STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("btn_debounce_ch: STABLE_TICKS, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    btn_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             level_r, level_nxt_s;
    logic             press_r, press_nxt_s;
    logic             release_r, release_nxt_s;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RPT_W-1:0] RPT_ZERO       = RPT_W'(0);
    localparam logic [RPT_W-1:0] RPT_ONE        = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_r, rpt_nxt_s;
    logic             rpt_first_r, rpt_first_nxt_s;
    logic [RPT_W-1:0] rpt_target_s;

    // Repeat target switches from the initial delay to the steady rate after the first repeat.
    always_comb begin
        rpt_target_s = RPT_DELAY_LAST;
        if (rpt_first_r) begin
            rpt_target_s = RPT_RATE_LAST;
        end else begin
            rpt_target_s = RPT_DELAY_LAST;
        end
    end

    // Repeat counter state, zero whenever the channel is outside PRESSED.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rpt_r       <= RPT_ZERO;
            rpt_first_r <= 1'b0;
        end else begin
            rpt_r       <= rpt_nxt_s;
            rpt_first_r <= rpt_first_nxt_s;
        end
    end
`endif

    // Next-state, counter and output decode; a bounce is tested before the tick.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        level_nxt_s   = level_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        rpt_nxt_s       = RPT_ZERO;
        rpt_first_nxt_s = 1'b0;
`endif
        case (state_r)
            RELEASED: begin
                if (btn_sync) begin
                    state_nxt_s = PRESS_CHK;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = RELEASED;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_nxt_s = RELEASED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (TICK) begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = PRESSED;
                        cnt_nxt_s   = CNT_ZERO;
                        level_nxt_s = 1'b1;
                        press_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = PRESS_CHK;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt_s = RELEASE_CHK;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = PRESSED;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
                    rpt_nxt_s       = rpt_r;
                    rpt_first_nxt_s = rpt_first_r;
                    if (TICK) begin
                        if (rpt_r == rpt_target_s) begin
                            rpt_nxt_s       = RPT_ZERO;
                            rpt_first_nxt_s = 1'b1;
                            press_nxt_s     = 1'b1;
                        end else begin
                            rpt_nxt_s = rpt_r + RPT_ONE;
                        end
                    end else begin
                        rpt_nxt_s = rpt_r;
                    end
`endif
                end
            end
            RELEASE_CHK: begin
                if (btn_sync) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (TICK) begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s   = RELEASED;
                        cnt_nxt_s     = CNT_ZERO;
                        level_nxt_s   = 1'b0;
                        release_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt_s = RELEASE_CHK;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = 1'b0;
            end
        endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r   <= RELEASED;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchroniser plus one btn_debounce_ch per button.
// Auto-repeat is enabled by defining BTN_DEBOUNCE_AUTO_REPEAT_EN.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_TICKS = 8,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               TICK,
    input  logic [NUM_BTN-1:0] BTN_IN,
    output logic [NUM_BTN-1:0] BTN_LEVEL,
    output logic [NUM_BTN-1:0] BTN_PRESS,
    output logic [NUM_BTN-1:0] BTN_RELEASE
);

    logic [NUM_BTN-1:0] sync_meta_r;
    logic [NUM_BTN-1:0] sync_r;

    // Two-stage synchroniser for the raw asynchronous button inputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync_meta_r <= {NUM_BTN{1'b0}};
            sync_r      <= {NUM_BTN{1'b0}};
        end else begin
            sync_meta_r <= BTN_IN;
            sync_r      <= sync_meta_r;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .CLOCK       (CLOCK),
            .RESET       (RESET),
            .TICK        (TICK),
            .btn_sync    (sync_r[i]),
            .btn_level   (BTN_LEVEL[i]),
            .btn_press   (BTN_PRESS[i]),
            .btn_release (BTN_RELEASE[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: expected pulse edges are queued at stimulus time and
// matched by a negedge monitor; level and reset values are checked inline.
module tb_btn_debounce;

    localparam int NB          = 4;
    localparam int ST          = 4;
    localparam int TICK_PERIOD = 10;

    typedef struct {
        int            edge_no;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } ev_t;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          TICK;
    logic [NB-1:0] BTN_IN;
    logic [NB-1:0] BTN_LEVEL;
    logic [NB-1:0] BTN_PRESS;
    logic [NB-1:0] BTN_RELEASE;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  cyc        = 0;
    int  tests      = 0;
    int  fails      = 0;
    bit  tick_stuck = 1'b0;
    bit  mon_en     = 1'b0;

    always #5 CLOCK = ~CLOCK;

    btn_debounce #(
        .NUM_BTN      (NB),
        .STABLE_TICKS (ST),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (2)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .TICK        (TICK),
        .BTN_IN      (BTN_IN),
        .BTN_LEVEL   (BTN_LEVEL),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; TICK for the following edge is set here (edge e ticks when e % 10 == 0).
    task automatic step();
        @(posedge CLOCK);
        cyc++;
        #1;
        TICK = tick_stuck ? 1'b1 : (((cyc + 1) % TICK_PERIOD) == 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int nth_tick_after(input int e0, input int n);
        int e;
        int k;
        e = e0;
        k = 0;
        if (tick_stuck) return e0 + n;
        while (k < n) begin
            e++;
            if ((e % TICK_PERIOD) == 0) k++;
        end
        return e;
    endfunction

    task automatic expect_ev(input int e, input logic [NB-1:0] p, input logic [NB-1:0] r);
        ev_t ev;
        ev.edge_no = e;
        ev.press   = p;
        ev.rel     = r;
        exp_q.push_back(ev);
    endtask

    // Pulse monitor: every press/release pulse must match the head of the expectation queue.
    always @(negedge CLOCK) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
                check("pulse_missed", 32'(cyc), 32'(exp_q[0].edge_no));
                void'(exp_q.pop_front());
            end
            if ((BTN_PRESS | BTN_RELEASE) != 4'b0000 ||
                (exp_q.size() > 0 && exp_q[0].edge_no == cyc)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({BTN_PRESS, BTN_RELEASE}), 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("pulse_edge", 32'(cyc), 32'(mon_ev.edge_no));
                    check("press_mask", 32'(BTN_PRESS), 32'(mon_ev.press));
                    check("release_mask", 32'(BTN_RELEASE), 32'(mon_ev.rel));
                end
            end
        end
    end

    initial begin
        int c;
        int a;
        int g;
        int r;
        int t;
        RESET  = 1'b1;
        TICK   = 1'b0;
        BTN_IN = 4'b0000;
        steps(3);
        check("reset_level", 32'(BTN_LEVEL), 32'd0);
        check("reset_press", 32'(BTN_PRESS), 32'd0);
        check("reset_release", 32'(BTN_RELEASE), 32'd0);
        RESET  = 1'b0;
        mon_en = 1'b1;
        steps(5);

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        // Auto-repeat: acceptance, +8 ticks, then every 2 ticks while held for 20 ticks.
        BTN_IN[2] = 1'b1;
        c = cyc;
        a = nth_tick_after(c + 3, ST);
        expect_ev(a, 4'b0100, 4'b0000);
        t = nth_tick_after(a, 8);
        expect_ev(t, 4'b0100, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            t = nth_tick_after(t, 2);
            expect_ev(t, 4'b0100, 4'b0000);
        end
        t = nth_tick_after(a, 19);
        steps(a - cyc + 1);
        check("rpt_level", 32'(BTN_LEVEL), 32'h4);
        steps(t - cyc);
        BTN_IN[2] = 1'b0;
        r = nth_tick_after(t + 3, ST);
        expect_ev(r, 4'b0000, 4'b0100);
        steps(r - cyc + 20);
        check("rpt_level_end", 32'(BTN_LEVEL), 32'd0);
`else
        // Clean press on channel 0.
        BTN_IN[0] = 1'b1;
        c = cyc;
        a = nth_tick_after(c + 3, ST);
        expect_ev(a, 4'b0001, 4'b0000);
        steps(a - c - 1);
        check("level_before_accept", 32'(BTN_LEVEL), 32'd0);
        steps(1);
        check("level_at_accept", 32'(BTN_LEVEL), 32'h1);
        steps(100 - (a - c));
        check("level_held", 32'(BTN_LEVEL), 32'h1);

        // Bounce on channel 1 never settles for four ticks.
        for (int i = 0; i < 20; i++) begin
            BTN_IN[1] = ~BTN_IN[1];
            steps(3);
            check("bounce_level", 32'(BTN_LEVEL), 32'h1);
        end
        BTN_IN[1] = 1'b0;
        steps(20);
        check("bounce_after", 32'(BTN_LEVEL), 32'h1);

        // Release with a one-clock glitch high during RELEASE_CHK.
        BTN_IN[0] = 1'b0;
        steps(15);
        BTN_IN[0] = 1'b1;
        g = cyc;
        step();
        BTN_IN[0] = 1'b0;
        r = nth_tick_after(g + 4, ST);
        expect_ev(r, 4'b0000, 4'b0001);
        steps(5);
        check("glitch_level", 32'(BTN_LEVEL), 32'h1);
        steps(r - cyc - 1);
        check("level_before_release", 32'(BTN_LEVEL), 32'h1);
        steps(1);
        check("level_after_release", 32'(BTN_LEVEL), 32'd0);
        steps(20);

        // Reset mid-check with channel 2 already pressed and channel 0 checking.
        BTN_IN[2] = 1'b1;
        c = cyc;
        a = nth_tick_after(c + 3, ST);
        expect_ev(a, 4'b0100, 4'b0000);
        steps(a - c + 5);
        check("ch2_level", 32'(BTN_LEVEL), 32'h4);
        BTN_IN[0] = 1'b1;
        c = cyc;
        t = nth_tick_after(c + 3, 2);
        steps(t - c);
        RESET = 1'b1;
        step();
        check("midrst_level", 32'(BTN_LEVEL), 32'd0);
        check("midrst_pulses", 32'({BTN_PRESS, BTN_RELEASE}), 32'd0);
        step();
        check("midrst_level2", 32'(BTN_LEVEL), 32'd0);
        RESET = 1'b0;
        r = nth_tick_after(t + 5, ST);
        expect_ev(r, 4'b0101, 4'b0000);
        steps(r - cyc - 1);
        check("rst_before_accept", 32'(BTN_LEVEL), 32'd0);
        steps(1);
        check("rst_after_accept", 32'(BTN_LEVEL), 32'h5);

        // Simultaneous release of channels 0 and 2, then simultaneous press of 0 and 3.
        BTN_IN = 4'b0000;
        c = cyc;
        expect_ev(nth_tick_after(c + 3, ST), 4'b0000, 4'b0101);
        steps(60);
        check("dual_release_level", 32'(BTN_LEVEL), 32'd0);
        BTN_IN = 4'b1001;
        c = cyc;
        a = nth_tick_after(c + 3, ST);
        expect_ev(a, 4'b1001, 4'b0000);
        steps(a - c + 2);
        check("dual_press_level", 32'(BTN_LEVEL), 32'h9);

        // Channel 1 drops exactly as its accepting tick arrives: bounce wins.
        BTN_IN[1] = 1'b1;
        c = cyc;
        a = nth_tick_after(c + 3, ST);
        steps(a - 3 - c);
        BTN_IN[1] = 1'b0;
        steps(10);
        check("late_bounce_level", 32'(BTN_LEVEL), 32'h9);
        steps(40);

        // TICK stuck high: every clock counts, channel 1 must start from RELEASED.
        tick_stuck = 1'b1;
        TICK = 1'b1;
        BTN_IN[1] = 1'b1;
        c = cyc;
        expect_ev(c + 3 + ST, 4'b0010, 4'b0000);
        steps(10);
        check("stuck_press_level", 32'(BTN_LEVEL), 32'hb);
        BTN_IN[1] = 1'b0;
        c = cyc;
        expect_ev(c + 3 + ST, 4'b0000, 4'b0010);
        steps(10);
        check("stuck_release_level", 32'(BTN_LEVEL), 32'h9);
        tick_stuck = 1'b0;
        TICK = (((cyc + 1) % TICK_PERIOD) == 0);

        BTN_IN = 4'b0000;
        c = cyc;
        expect_ev(nth_tick_after(c + 3, ST), 4'b0000, 4'b1001);
        steps(60);
        check("final_level", 32'(BTN_LEVEL), 32'd0);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Multi-channel push-button debouncer; the downstream consumer of the clock divider's 1-cycle enable strobe, which drives TICK.
- Synchronises raw asynchronous button inputs to CLOCK.
- Accepts a level change only after it has been stable for STABLE_TICKS strobes.
- Emits a debounced level plus 1-cycle press/release pulses to control logic.

Parameters:
- NUM_BTN, 4: number of independent button channels (>=1).
- STABLE_TICKS, 8: TICK strobes an input must stay stable before acceptance (>=1).
- REPEAT_DELAY, 400: TICKs held before the first auto-repeat pulse (optional feature only).
- REPEAT_RATE, 100: TICKs between subsequent auto-repeat pulses (optional feature only).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  1-cycle enable strobe from the clock divider; may be high on any cycle.
- BTN_IN  in  NUM_BTN  raw asynchronous button inputs; 1 = pressed.
- BTN_LEVEL  out  NUM_BTN  debounced level, registered.
- BTN_PRESS  out  NUM_BTN  1-cycle pulse on accepted press.
- BTN_RELEASE  out  NUM_BTN  1-cycle pulse on accepted release.

Behaviour:
- Reset: synchroniser flops, all outputs and all counters = 0; every channel in RELEASED. Reset overrides everything on the same edge.
- Synchroniser: 2-flop per bit on CLOCK; channel logic sees only the synced bit s.
- Counter: cnt width $clog2(STABLE_TICKS+1); cnt never exceeds STABLE_TICKS-1.
- Channel FSM; every transition not listed below holds state and cnt:
  - RELEASED: s=1 -> PRESS_CHK, cnt=0 (on any cycle, TICK not required).
  - PRESS_CHK, s=0: -> RELEASED, cnt=0, no pulse. Checked first; a bounce wins over a coincident TICK.
  - PRESS_CHK, s=1 and TICK, cnt==STABLE_TICKS-1: -> PRESSED; BTN_LEVEL<=1, BTN_PRESS<=1 for one cycle.
  - PRESS_CHK, s=1 and TICK, cnt<STABLE_TICKS-1: cnt<=cnt+1.
  - PRESSED: s=0 -> RELEASE_CHK, cnt=0.
  - RELEASE_CHK: mirror of PRESS_CHK. s=1 returns to PRESSED with no pulse. Acceptance -> RELEASED; BTN_LEVEL<=0, BTN_RELEASE<=1 for one cycle.
- Pulse timing: BTN_PRESS/BTN_RELEASE assert on the same edge BTN_LEVEL changes; both deassert the next cycle unless re-asserted.
- Latency: raw edge -> s takes 2 CLOCKs; +1 CLOCK to enter CHK; acceptance occurs on the STABLE_TICKS-th TICK seen in CHK. Effective filter window is between STABLE_TICKS-1 and STABLE_TICKS TICK periods.
- Channels are fully independent; simultaneous pulses on several bits are legal.
- TICK stuck high: each CLOCK counts as a tick; the channel must still function.
- Reset mid-check: pending state discarded. A still-held button re-debounces from RELEASED, and its press pulse is emitted after reset release.

Optional Feature:
- Macro BTN_DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - A per-channel repeat counter clears on entry to PRESSED.
  - While in PRESSED, an extra BTN_PRESS pulse fires after REPEAT_DELAY TICKs, then every REPEAT_RATE TICKs.
  - Leaving PRESSED clears the repeat counter.
  - BTN_LEVEL is unaffected.
- Undefined: the repeat logic and its parameters are unused; exactly one BTN_PRESS per accepted press.

Decomposition:
- Shared package/include:
  - FSM state encodings RELEASED=2'd0, PRESS_CHK=2'd1, PRESSED=2'd2, RELEASE_CHK=2'd3.
  - Counter-width helper constant.
- Sub-module btn_debounce_ch: one channel (FSM, counters, output regs), instantiated NUM_BTN times via generate.
- The synchroniser stays in the top level.

Test Plan (STABLE_TICKS=4; bench drives TICK every 10 CLOCKs):
1. Clean press: BTN_IN[0] 0->1 held 100 CLOCKs -> exactly one BTN_PRESS[0] pulse, on the 4th TICK after CHK entry; BTN_LEVEL[0]=1 from that edge; other bits stay 0.
2. Bounce rejection: BTN_IN[1] toggles every 3 CLOCKs for 60 CLOCKs, then held 0 -> no pulses, BTN_LEVEL[1]=0 throughout.
3. Release: from PRESSED, BTN_IN[0]->0 held -> one BTN_RELEASE[0] pulse on the 4th TICK; BTN_LEVEL[0]=0. A 1-CLOCK glitch high during RELEASE_CHK -> stays PRESSED, no pulse.
4. Reset mid-check: RESET for 2 CLOCKs after the 2nd TICK in PRESS_CHK, input still high -> outputs 0 during reset; BTN_PRESS[0] occurs on the 4th TICK after CHK re-entry.
5. Simultaneous events: BTN_IN[0] and BTN_IN[3] rise on the same cycle -> pulses on the same cycle. Separately, s drops on the same cycle as the accepting TICK -> no pulse, channel returns to RELEASED.
6. Auto-repeat (macro defined, REPEAT_DELAY=8, REPEAT_RATE=2; hold 20 TICKs) -> pulses at acceptance, +8 TICKs, then every 2 TICKs, 7 pulses in total. Macro undefined -> 1 pulse.
